gelato_multi_fetch_scheduler: RTL and testbench

GELATO_MULTI_FETCH_SCHEDULER -- requirements
Module: gelato_multi_fetch_scheduler

---
 rtl/gelato_fetch_pkg.sv | 17 +
 rtl/gelato_rr_arbiter.sv | 31 +++
 rtl/gelato_multi_fetch_scheduler.sv | 152 +++++++++++++++
 tb/tb_gelato_multi_fetch_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gelato_fetch_pkg.sv
// Shared types and default sizing for the GELATO multi-warp fetch scheduler.
package gelato_fetch_pkg;

  localparam int DEF_NUM_WARPS       = 8;
  localparam int DEF_PC_WIDTH        = 32;
  localparam int DEF_IBUF_DEPTH      = 4;
  localparam int DEF_MAX_OUTSTANDING = 2;

  typedef logic [$clog2(DEF_NUM_WARPS)-1:0] warp_id_t;
  typedef logic [DEF_PC_WIDTH-1:0]          pc_t;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_HOLD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N.
module gelato_rr_arbiter #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id
);

  localparam int ID_W = $clog2(N);

  logic [ID_W-1:0] idx_s;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = {ID_W{1'b0}};
    idx_s       = {ID_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx_s = ptr + i[ID_W-1:0];
      if (req[idx_s]) begin
        grant_valid = 1'b1;
        grant_id    = idx_s;
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/gelato_multi_fetch_scheduler.sv
// Credit- and outstanding-limited round-robin fetch scheduler with a
// registered valid/ready request port.
module gelato_multi_fetch_scheduler
  import gelato_fetch_pkg::*;
#(
  parameter int NUM_WARPS       = DEF_NUM_WARPS,
  parameter int PC_WIDTH        = DEF_PC_WIDTH,
  parameter int IBUF_DEPTH      = DEF_IBUF_DEPTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic [NUM_WARPS-1:0]          warp_active,
  input  logic [NUM_WARPS*PC_WIDTH-1:0] warp_pc,
  output logic                          fetch_valid,
  input  logic                          fetch_ready,
  output logic [$clog2(NUM_WARPS)-1:0]  fetch_warp_id,
  output logic [PC_WIDTH-1:0]           fetch_pc,
  input  logic                          resp_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]  resp_warp_id,
  input  logic                          pop_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]  pop_warp_id,
  input  logic                          flush_valid,
  input  logic [$clog2(NUM_WARPS)-1:0]  flush_warp_id
);

  localparam int ID_W = $clog2(NUM_WARPS);
  localparam int CR_W = $clog2(IBUF_DEPTH + 1);
  localparam int OS_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CR_W-1:0] CREDIT_FULL = CR_W'(IBUF_DEPTH);
  localparam logic [OS_W-1:0] OS_LIMIT    = OS_W'(MAX_OUTSTANDING);

  fetch_state_t           state_r;
  logic [CR_W-1:0]        credit_r [NUM_WARPS];
  logic [CR_W-1:0]        credit_s [NUM_WARPS];
  logic [NUM_WARPS-1:0]   pending_r, pending_hs_s, pending_s, eligible_s;
  logic [NUM_WARPS-1:0]   hs_vec_s, pop_vec_s, flush_vec_s;
  logic [OS_W-1:0]        outstanding_r, outstanding_s;
  logic [ID_W-1:0]        rr_ptr_r, arb_ptr_s, grant_id_s;
  logic                   grant_valid_s, hs_s, resp_ok_s, drop_s;
  logic [PC_WIDTH-1:0]    grant_pc_s;

  // Post-update counters; eligibility is judged on them so a handshake can chain into the next grant.
  always_comb begin
    hs_s        = fetch_valid & fetch_ready;
    resp_ok_s   = resp_valid & pending_r[resp_warp_id];
    hs_vec_s    = hs_s ? (NUM_WARPS'(1) << fetch_warp_id) : {NUM_WARPS{1'b0}};
    pop_vec_s   = pop_valid ? (NUM_WARPS'(1) << pop_warp_id) : {NUM_WARPS{1'b0}};
    flush_vec_s = flush_valid ? (NUM_WARPS'(1) << flush_warp_id) : {NUM_WARPS{1'b0}};
    drop_s      = flush_valid & fetch_valid & ~hs_s & (flush_warp_id == fetch_warp_id);
    pending_hs_s = pending_r | hs_vec_s;
    pending_s    = pending_hs_s;
    if (resp_ok_s) begin
      pending_s[resp_warp_id] = 1'b0;
    end else begin
      pending_s = pending_hs_s;
    end
    outstanding_s = outstanding_r + OS_W'(hs_s) - OS_W'(resp_ok_s);
    for (int w = 0; w < NUM_WARPS; w++) begin
      credit_s[w] = credit_r[w];
      if (flush_vec_s[w]) begin
        credit_s[w] = CREDIT_FULL - CR_W'(pending_hs_s[w]);
      end else if (hs_vec_s[w] && !pop_vec_s[w]) begin
        credit_s[w] = credit_r[w] - CR_W'(1);
      end else if (pop_vec_s[w] && !hs_vec_s[w] && (credit_r[w] != CREDIT_FULL)) begin
        credit_s[w] = credit_r[w] + CR_W'(1);
      end else begin
        credit_s[w] = credit_r[w];
      end
      eligible_s[w] = warp_active[w] & ~pending_s[w] & (credit_s[w] != {CR_W{1'b0}})
                      & (outstanding_s < OS_LIMIT);
    end
    if (hs_s) begin
      arb_ptr_s = fetch_warp_id + ID_W'(1);
    end else begin
      arb_ptr_s = rr_ptr_r;
    end
    grant_pc_s = warp_pc[grant_id_s*PC_WIDTH +: PC_WIDTH];
  end

  gelato_rr_arbiter #(.N(NUM_WARPS)) u_arb (
    .req         (eligible_s),
    .ptr         (arb_ptr_s),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Per-warp credit/pending bookkeeping and the global outstanding count.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        credit_r[w] <= CREDIT_FULL;
      end
      pending_r     <= {NUM_WARPS{1'b0}};
      outstanding_r <= {OS_W{1'b0}};
      rr_ptr_r      <= {ID_W{1'b0}};
    end else if (rdy) begin
      credit_r      <= credit_s;
      pending_r     <= pending_s;
      outstanding_r <= outstanding_s;
      if (hs_s) begin
        rr_ptr_r <= fetch_warp_id + ID_W'(1);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end else begin
      pending_r <= pending_r;
    end
  end

  // Request FSM; HOLD keeps id/pc frozen until handshake or a flush of the held warp.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= FETCH_IDLE;
      fetch_valid   <= 1'b0;
      fetch_warp_id <= {ID_W{1'b0}};
      fetch_pc      <= {PC_WIDTH{1'b0}};
    end else if (rdy) begin
      case (state_r)
        FETCH_IDLE: begin
          if (grant_valid_s) begin
            state_r       <= FETCH_HOLD;
            fetch_valid   <= 1'b1;
            fetch_warp_id <= grant_id_s;
            fetch_pc      <= grant_pc_s;
          end else begin
            state_r <= FETCH_IDLE;
          end
        end
        FETCH_HOLD: begin
          if (hs_s && grant_valid_s) begin
            fetch_warp_id <= grant_id_s;
            fetch_pc      <= grant_pc_s;
          end else if (hs_s || drop_s) begin
            state_r     <= FETCH_IDLE;
            fetch_valid <= 1'b0;
          end else begin
            state_r <= FETCH_HOLD;
          end
        end
        default: begin
          state_r     <= FETCH_IDLE;
          fetch_valid <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

endmodule

// File: tb/tb_gelato_multi_fetch_scheduler.sv
// Vector table, directed corner sequences and a randomized run against a
// behavioural scheduler model.
module tb_gelato_multi_fetch_scheduler;
  import gelato_fetch_pkg::*;

  localparam int N  = 8;
  localparam int PW = 32;
  localparam int D  = 4;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst, rdy, fetch_ready, fetch_valid;
  logic [N-1:0]  warp_active;
  logic [N*PW-1:0] warp_pc;
  warp_id_t      fetch_warp_id, resp_warp_id, pop_warp_id, flush_warp_id;
  logic [PW-1:0] fetch_pc;
  logic          resp_valid, pop_valid, flush_valid;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // behavioural model state
  int          m_cred [N];
  bit          m_pend [N];
  int          m_out, m_rr, m_id;
  bit          m_v;
  logic [PW-1:0] m_pc;

  gelato_multi_fetch_scheduler dut (
    .clk(clk), .rst(rst), .rdy(rdy), .warp_active(warp_active), .warp_pc(warp_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_warp_id(fetch_warp_id),
    .fetch_pc(fetch_pc), .resp_valid(resp_valid), .resp_warp_id(resp_warp_id),
    .pop_valid(pop_valid), .pop_warp_id(pop_warp_id), .flush_valid(flush_valid),
    .flush_warp_id(flush_warp_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst_v, rdy_v; logic [7:0] act; logic rdy_in;
    logic rv; logic [2:0] rid; logic ev; logic chk_id; logic [2:0] eid;
  } vec_t;

  function automatic vec_t mk(logic r, logic e, logic [7:0] a, logic fr, logic rv,
                              logic [2:0] rid, logic ev, logic ci, logic [2:0] eid);
    vec_t v;
    v.rst_v = r; v.rdy_v = e; v.act = a; v.rdy_in = fr; v.rv = rv; v.rid = rid;
    v.ev = ev; v.chk_id = ci; v.eid = eid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic set_pc(input int w, input logic [PW-1:0] v);
    warp_pc[w*PW +: PW] = v;
  endtask

  // Spec rules applied to the pre-edge state with the inputs of this edge.
  task automatic model_step();
    bit hs, rok;
    int w;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_cred[i] = D; m_pend[i] = 0; end
      m_out = 0; m_rr = 0; m_v = 0; m_id = 0; m_pc = '0;
    end else if (rdy) begin
      hs  = m_v && fetch_ready;
      rok = resp_valid && m_pend[resp_warp_id];
      if (hs) begin
        m_pend[m_id] = 1; m_cred[m_id] -= 1; m_out += 1; m_rr = (m_id + 1) % N;
      end
      if (pop_valid) m_cred[pop_warp_id] = (m_cred[pop_warp_id] + 1 > D) ? D : m_cred[pop_warp_id] + 1;
      if (flush_valid) m_cred[flush_warp_id] = D - int'(m_pend[flush_warp_id]);
      if (rok) begin m_pend[resp_warp_id] = 0; m_out -= 1; end
      if (m_v && !hs) begin
        if (flush_valid && int'(flush_warp_id) == m_id) m_v = 0;
      end else begin
        m_v = 0;
        for (int k = 0; k < N; k++) begin
          w = (m_rr + k) % N;
          if (!m_v && warp_active[w] && !m_pend[w] && m_cred[w] > 0 && m_out < MO) begin
            m_v = 1; m_id = w; m_pc = warp_pc[w*PW +: PW];
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; resp_valid = 1'b0; pop_valid = 1'b0; flush_valid = 1'b0;
    resp_warp_id = '0; pop_warp_id = '0; flush_warp_id = '0;
  endtask

  task automatic do_reset(input logic [7:0] act, input logic fr);
    idle_inputs();
    warp_active = act; fetch_ready = fr; rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Counts handshakes with fetch_ready=1, answering each fetch one cycle later.
  task automatic count_fetches(input int iters, input int wid, output int cnt);
    bit flag;
    flag = 0; cnt = 0;
    fetch_ready = 1'b1;
    for (int i = 0; i < iters; i++) begin
      resp_valid = flag; resp_warp_id = wid[2:0];
      flag = fetch_valid;
      if (fetch_valid) cnt++;
      tick();
    end
    resp_valid = 1'b0;
  endtask

  initial begin
    vec_t tbl [10];
    int cnt;
    logic [31:0] exp_pc;
    warp_pc = '0;
    for (int i = 0; i < N; i++) set_pc(i, 32'(i) * 32'h100);
    idle_inputs();
    rst = 1'b1; fetch_ready = 1'b0; warp_active = '0;

    // warps 0,3,5 active; resps re-open the outstanding window
    tbl[0] = mk(1'b1, 1'b1, 8'h29, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0);
    tbl[1] = mk(1'b0, 1'b1, 8'h29, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd0);
    tbl[2] = mk(1'b0, 1'b1, 8'h29, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 3'd3);
    tbl[3] = mk(1'b0, 1'b1, 8'h29, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    tbl[4] = mk(1'b0, 1'b1, 8'h29, 1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 3'd5);
    tbl[5] = mk(1'b0, 1'b1, 8'h29, 1'b1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd0);
    tbl[6] = mk(1'b0, 1'b1, 8'h29, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    tbl[7] = mk(1'b0, 1'b0, 8'h29, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 3'd0);
    tbl[8] = mk(1'b0, 1'b1, 8'h29, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
    tbl[9] = mk(1'b0, 1'b1, 8'h29, 1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 3'd3);

    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst_v; rdy = tbl[i].rdy_v; warp_active = tbl[i].act;
      fetch_ready = tbl[i].rdy_in; resp_valid = tbl[i].rv; resp_warp_id = tbl[i].rid;
      tick();
      exp_pc = 32'(tbl[i].eid) * 32'h100;
      chk($sformatf("tbl%0d_valid", i), 64'(fetch_valid), 64'(tbl[i].ev));
      if (tbl[i].chk_id) begin
        chk($sformatf("tbl%0d_id", i), 64'(fetch_warp_id), 64'(tbl[i].eid));
        chk($sformatf("tbl%0d_pc", i), 64'(fetch_pc), 64'(exp_pc));
      end
    end

    // credit exhaustion on warp 2, then one pop buys exactly one more fetch
    do_reset(8'h04, 1'b1);
    tick();
    count_fetches(16, 2, cnt);
    chk("credit_fetches", 64'(cnt), 64'd4);
    chk("credit_empty_valid", 64'(fetch_valid), 64'd0);
    pop_valid = 1'b1; pop_warp_id = 3'd2;
    tick();
    pop_valid = 1'b0;
    chk("pop_regrant_valid", 64'(fetch_valid), 64'd1);
    count_fetches(8, 2, cnt);
    chk("pop_one_fetch", 64'(cnt), 64'd1);
    chk("pop_then_empty", 64'(fetch_valid), 64'd0);

    // stalled HOLD: id/pc stable despite pc change and warp deactivation
    do_reset(8'h02, 1'b0);
    tick();
    warp_active = 8'h00; set_pc(1, 32'h999);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 64'(fetch_valid), 64'd1);
      chk("hold_id", 64'(fetch_warp_id), 64'd1);
      chk("hold_pc", 64'(fetch_pc), 64'h100);
    end
    fetch_ready = 1'b1;
    tick();
    chk("hold_hs_valid", 64'(fetch_valid), 64'd0);
    set_pc(1, 32'h100); warp_active = 8'h02; resp_valid = 1'b1; resp_warp_id = 3'd1;
    tick();
    resp_valid = 1'b0;
    chk("hold_after_resp", 64'(fetch_valid), 64'd1);
    count_fetches(12, 1, cnt);
    chk("hold_one_hs", 64'(cnt), 64'd3);

    // flush+pop on warp 4 while credit=1 and a fetch is pending
    do_reset(8'h10, 1'b1);
    tick();
    tick();
    resp_valid = 1'b1; resp_warp_id = 3'd4; tick();
    resp_valid = 1'b0; tick();
    resp_valid = 1'b1; tick();
    resp_valid = 1'b0; tick();
    chk("w4_pending_valid", 64'(fetch_valid), 64'd0);
    flush_valid = 1'b1; flush_warp_id = 3'd4; pop_valid = 1'b1; pop_warp_id = 3'd4;
    tick();
    flush_valid = 1'b0; pop_valid = 1'b0;
    chk("w4_flush_still_pending", 64'(fetch_valid), 64'd0);
    resp_valid = 1'b1; tick();
    resp_valid = 1'b0;
    chk("w4_resp_regrant", 64'(fetch_valid), 64'd1);
    count_fetches(12, 4, cnt);
    chk("w4_flush_credit3", 64'(cnt), 64'd3);

    // rdy low freezes a HOLD with fetch_ready high
    do_reset(8'h40, 1'b1);
    tick();
    rdy = 1'b0; pop_valid = 1'b1; pop_warp_id = 3'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_valid", 64'(fetch_valid), 64'd1);
      chk("frz_id", 64'(fetch_warp_id), 64'd6);
    end
    rdy = 1'b1; pop_valid = 1'b0;
    tick();
    chk("frz_release_hs", 64'(fetch_valid), 64'd0);
    resp_valid = 1'b1; resp_warp_id = 3'd6; tick();
    resp_valid = 1'b0;
    count_fetches(12, 6, cnt);
    chk("frz_credit3", 64'(cnt), 64'd3);

    // flush of the held warp without handshake drops the request
    do_reset(8'h80, 1'b0);
    tick();
    flush_valid = 1'b1; flush_warp_id = 3'd7;
    tick();
    flush_valid = 1'b0;
    chk("drop_valid", 64'(fetch_valid), 64'd0);
    tick();
    chk("drop_regrant", 64'(fetch_valid), 64'd1);

    // randomized run against the model
    do_reset(8'hff, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) warp_active = 8'($urandom);
      if ($urandom_range(0, 7) == 0) set_pc($urandom_range(0, N - 1), $urandom);
      fetch_ready  = ($urandom_range(0, 9) < 6);
      resp_valid   = ($urandom_range(0, 1) == 1); resp_warp_id  = 3'($urandom_range(0, N - 1));
      pop_valid    = ($urandom_range(0, 9) < 3);  pop_warp_id   = 3'($urandom_range(0, N - 1));
      flush_valid  = ($urandom_range(0, 19) == 0); flush_warp_id = 3'($urandom_range(0, N - 1));
      tick();
      chk("rnd_valid", 64'(fetch_valid), 64'(m_v));
      if (m_v) begin
        chk("rnd_id", 64'(fetch_warp_id), 64'(m_id));
        chk("rnd_pc", 64'(fetch_pc), 64'(m_pc));
      end
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
